// File: rtl/fft4_pkg.sv
// Shared definitions for the 4-point FFT/IFFT pair.
// Widths, FSM encoding and the complex sample bundle.
package fft4_pkg;

  localparam int FFT_IN_W  = 8;
  localparam int FFT_OUT_W = FFT_IN_W + 2;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [FFT_OUT_W-1:0] re;
    logic signed [FFT_OUT_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft4_butterfly.sv
// Combinational radix-2 4-point forward FFT core.
// Exact arithmetic: inputs widen by 2 bits, no scaling.
module fft4_butterfly
  import fft4_pkg::*;
#(
  parameter int IN_W = FFT_IN_W
) (
  input  logic signed [IN_W-1:0]   a_re [4],
  input  logic signed [IN_W-1:0]   a_im [4],
  output logic signed [IN_W+1:0]   x_re [4],
  output logic signed [IN_W+1:0]   x_im [4]
);

  localparam int OUT_W = IN_W + 2;

  logic signed [OUT_W-1:0] e_re [4];
  logic signed [OUT_W-1:0] e_im [4];
  logic signed [OUT_W-1:0] t_re [4];
  logic signed [OUT_W-1:0] t_im [4];

  // Sign-extend first, then two butterfly ranks.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      e_re[i] = {{2{a_re[i][IN_W-1]}}, a_re[i]};
      e_im[i] = {{2{a_im[i][IN_W-1]}}, a_im[i]};
    end
    t_re[0] = e_re[0] + e_re[2];
    t_im[0] = e_im[0] + e_im[2];
    t_re[1] = e_re[0] - e_re[2];
    t_im[1] = e_im[0] - e_im[2];
    t_re[2] = e_re[1] + e_re[3];
    t_im[2] = e_im[1] + e_im[3];
    t_re[3] = e_re[1] - e_re[3];
    t_im[3] = e_im[1] - e_im[3];
    x_re[0] = t_re[0] + t_re[2];
    x_im[0] = t_im[0] + t_im[2];
    x_re[2] = t_re[0] - t_re[2];
    x_im[2] = t_im[0] - t_im[2];
    x_re[1] = t_re[1] + t_im[3];
    x_im[1] = t_im[1] - t_re[3];
    x_re[3] = t_re[1] - t_im[3];
    x_im[3] = t_im[1] + t_re[3];
  end

endmodule

// File: rtl/fft4_stream.sv
// Streaming 4-point forward FFT: collect 4 samples,
// compute in one cycle, emit 4 bins over valid/ready.
module fft4_stream
  import fft4_pkg::*;
#(
  parameter int IN_W = FFT_IN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sof,
  input  logic signed [IN_W-1:0] in_re,
  input  logic signed [IN_W-1:0] in_im,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [IN_W+1:0] out_re,
  output logic signed [IN_W+1:0] out_im,
  output logic [1:0]             out_idx,
  output logic                   out_last,
  output logic                   sync_err
);

  localparam int OUT_W = IN_W + 2;

  state_t                  state;
  logic [1:0]              cnt;
  logic [1:0]              oidx;
  logic signed [IN_W-1:0]  buf_re [4];
  logic signed [IN_W-1:0]  buf_im [4];
  logic signed [OUT_W-1:0] res_re [4];
  logic signed [OUT_W-1:0] res_im [4];
  logic signed [OUT_W-1:0] bf_re  [4];
  logic signed [OUT_W-1:0] bf_im  [4];
  logic [1:0]              slot;
  logic                    in_fire;
  logic                    out_fire;

  fft4_butterfly #(.IN_W(IN_W)) u_bf (
    .a_re (buf_re),
    .a_im (buf_im),
    .x_re (bf_re),
    .x_im (bf_im)
  );

  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == EMIT);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign slot      = in_sof ? 2'd0 : cnt;
  assign out_idx   = oidx;
  assign out_last  = out_valid && (oidx == 2'd3);
  assign out_re    = res_re[oidx];
  assign out_im    = res_im[oidx];

  // Frame FSM: collect, register butterflies, emit bins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= COLLECT;
      cnt      <= 2'd0;
      oidx     <= 2'd0;
      sync_err <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        buf_re[i] <= '0;
        buf_im[i] <= '0;
        res_re[i] <= '0;
        res_im[i] <= '0;
      end
    end else begin
      sync_err <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (in_fire) begin
            buf_re[slot] <= in_re;
            buf_im[slot] <= in_im;
            if (in_sof) begin
              cnt      <= 2'd1;
              sync_err <= (cnt != 2'd0);
            end else if (cnt == 2'd3) begin
              cnt   <= 2'd0;
              state <= COMPUTE;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        COMPUTE: begin
          for (int i = 0; i < 4; i++) begin
            res_re[i] <= bf_re[i];
            res_im[i] <= bf_im[i];
          end
          oidx  <= 2'd0;
          state <= EMIT;
        end
        EMIT: begin
          if (out_fire) begin
            if (oidx == 2'd3) begin
              oidx  <= 2'd0;
              state <= COLLECT;
            end else begin
              oidx <= oidx + 2'd1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_fft4_stream.sv
// Scoreboard bench for fft4_stream.
// Directed frames with hand-computed bins.
module tb_fft4_stream;
  import fft4_pkg::*;

  localparam int IN_W  = 8;
  localparam int OUT_W = IN_W + 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic                   in_sof = 1'b0;
  logic signed [IN_W-1:0] in_re = '0;
  logic signed [IN_W-1:0] in_im = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic signed [OUT_W-1:0] out_re;
  logic signed [OUT_W-1:0] out_im;
  logic [1:0]             out_idx;
  logic                   out_last;
  logic                   sync_err;

  typedef struct {
    cplx_t v;
    int    idx;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   first_cyc = 0;
  int   sync_cnt = 0;

  fft4_stream #(.IN_W(IN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare each transferred bin against the queue head.
  always @(negedge clk) begin
    if (rst_n && sync_err) sync_cnt++;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_bin", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("bin_re", int'(out_re), int'(e.v.re));
        chk("bin_im", int'(out_im), int'(e.v.im));
        chk("bin_idx", int'(out_idx), e.idx);
        chk("bin_last", int'(out_last), int'(e.idx == 3));
        if (out_last) last_cyc = cyc + 1;
      end
    end
  end

  task automatic expect_bin(input int k, input int re, input int im);
    exp_t e;
    e.idx  = k;
    e.v.re = OUT_W'(re);
    e.v.im = OUT_W'(im);
    q.push_back(e);
  endtask

  task automatic send(input int re, input int im, input bit sof);
    int n = 0;
    in_valid = 1'b1;
    in_sof   = sof;
    in_re    = IN_W'(re);
    in_im    = IN_W'(im);
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        chk("in_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic frame(input int r0, i0, r1, i1, r2, i2, r3, i3,
                       input bit sof);
    send(r0, i0, sof);
    first_cyc = cyc;
    send(r1, i1, 1'b0);
    send(r2, i2, 1'b0);
    send(r3, i3, 1'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_re", int'(out_re), 0);
    chk("rst_out_im", int'(out_im), 0);
    chk("rst_out_idx", int'(out_idx), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_sync_err", int'(sync_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Impulse
    expect_bin(0, 1, 0); expect_bin(1, 1, 0);
    expect_bin(2, 1, 0); expect_bin(3, 1, 0);
    frame(1, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    wait_idle();

    // DC, also minimum 9-cycle frame
    expect_bin(0, 40, 0); expect_bin(1, 0, 0);
    expect_bin(2, 0, 0); expect_bin(3, 0, 0);
    frame(10, 0, 10, 0, 10, 0, 10, 0, 1'b1);
    wait_idle();
    chk("frame_cycles", last_cyc - first_cyc, 8);

    // Delayed impulse
    expect_bin(0, 1, 0); expect_bin(1, 0, -1);
    expect_bin(2, -1, 0); expect_bin(3, 0, 1);
    frame(0, 0, 1, 0, 0, 0, 0, 0, 1'b1);
    wait_idle();

    // Extremes
    expect_bin(0, -512, -512); expect_bin(1, 0, 0);
    expect_bin(2, 0, 0); expect_bin(3, 0, 0);
    frame(-128, -128, -128, -128, -128, -128, -128, -128, 1'b1);
    wait_idle();
    expect_bin(0, 508, 508); expect_bin(1, 0, 0);
    expect_bin(2, 0, 0); expect_bin(3, 0, 0);
    frame(127, 127, 127, 127, 127, 127, 127, 127, 1'b1);
    wait_idle();

    // Backpressure on bin 1
    expect_bin(0, 16, 20); expect_bin(1, -8, 0);
    expect_bin(2, -4, -4); expect_bin(3, 0, -8);
    frame(1, 2, 3, 4, 5, 6, 7, 8, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_idx", int'(out_idx), 1);
      chk("bp_re", int'(out_re), -8);
      chk("bp_im", int'(out_im), 0);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_last", int'(out_last), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle();

    // Resync: partial frame of 2, then sof
    sync_cnt = 0;
    send(9, 9, 1'b1);
    send(9, 9, 1'b0);
    expect_bin(0, 16, 20); expect_bin(1, -8, 0);
    expect_bin(2, -4, -4); expect_bin(3, 0, -8);
    frame(1, 2, 3, 4, 5, 6, 7, 8, 1'b1);
    wait_idle();
    chk("sync_err_pulses", sync_cnt, 1);

    // Reset during EMIT
    out_ready = 1'b0;
    frame(1, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    @(posedge clk); #1;
    chk("pre_rst_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_idx", int'(out_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", int'(in_ready), 1);

    // Free-running frame without sof proves cnt restarted at 0
    expect_bin(0, 1, 0); expect_bin(1, 0, -1);
    expect_bin(2, -1, 0); expect_bin(3, 0, 1);
    frame(0, 0, 1, 0, 0, 0, 0, 0, 1'b0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
